fp_mult_arbiter: RTL and testbench
==================================

// Module: fp_mult_arbiter
// PURPOSE
// - Shares one multi-cycle FP32 multiplier core (multiplier + exception stage) between two requesters.
// - Round-robin grant, operand capture, one-cycle start pulse to the core, then result/flag capture.
// - Results return on a valid/ready response channel tagged to the granted requester.
// - Sits between client datapaths and the shared core; one operation is in flight at a time.
// PARAMETERS
// - TIMEOUT_CYCLES  default 64  WAIT cycles before watchdog abort (used only with FP_MULT_ARB_TIMEOUT_EN); >=2
// - TW              default 7   counter width; must satisfy 2**TW > TIMEOUT_CYCLES
// PORTS
// - clk         in   1   clock, rising edge
// - rst_n       in   1   asynchronous active-low reset
// - req_valid   in   2   bit i: requester i has an operand pair
// - req_ready   out  2   bit i: requester i accepted this cycle
// - req_a       in   64  [32i+31:32i] = operand a of requester i
// - req_b       in   64  [32i+31:32i] = operand b of requester i
// - rsp_valid   out  2   bit i: response for requester i pending (one-hot or 0)
// - rsp_ready   in   2   bit i: requester i takes its response
// - rsp_z       out  32  result word
// - rsp_status  out  7   {timeout,inexact,huge,tiny,nan,inf,zero}
// - mul_start   out  1   one-cycle start pulse to the core
// - mul_a       out  32  registered operand a to the core
// - mul_b       out  32  registered operand b to the core
// - mul_done    in   1   core result valid, single-cycle pulse
// - mul_z       in   32  core result
// - mul_flags   in   6   {inexact,huge,tiny,nan,inf,zero} from the exception stage
// BEHAVIOUR
// - Reset: state=IDLE, last_grant=1, owner=0, req_ready=0, rsp_valid=0, mul_start=0, mul_a/mul_b/rsp_z=0, rsp_status=0, counter=0.
// - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// - IDLE: winner = only valid requester; if both valid, winner = !last_grant. req_ready[winner]=1 combinationally
//   (only in IDLE). On accept: mul_a/mul_b <= winner operands, owner <= winner, last_grant <= winner, -> ISSUE.
// - ISSUE: mul_start=1 for exactly this cycle; -> WAIT. req_ready=0 in every state but IDLE.
// - WAIT: on mul_done: rsp_z <= mul_z, rsp_status <= {1'b0, mul_flags}, -> RESP. mul_done outside WAIT ignored.
// - RESP: rsp_valid[owner]=1, rsp_z/rsp_status held stable; on rsp_ready[owner] -> IDLE. rsp_ready[!owner] ignored.
// - Latency: accept at T, mul_start at T+1, rsp_valid at cycle after mul_done (earliest T+3 for 1-cycle core).
// - Back-to-back: new accept earliest in cycle after response handshake (IDLE re-entered); fairness alternates under continuous contention.
// - req_valid drop while not granted: no effect, no state change. Operands sampled only on accept.
// - Reset mid-operation: immediate return to reset values; in-flight op discarded, no response. Core shares rst_n so no stale mul_done.
// - Flags pass through unmodified; the arbiter does not recompute exception cases.
// CONFIGURATION
// - FP_MULT_ARB_TIMEOUT_EN defined: counter clears on entry to WAIT, increments each WAIT cycle; when it reaches
//   TIMEOUT_CYCLES without mul_done: rsp_z <= 32'h7FC0_0000, rsp_status <= 7'b100_0100 (timeout|nan), -> RESP.
//   mul_done in the same cycle as expiry wins (normal result). Late mul_done after abort is ignored.
// - Not defined: no counter logic, WAIT holds indefinitely, rsp_status[6] tied 0.
// TESTING
// - Reset mid-WAIT: all outputs return to reset values same cycle; next request issues normally.
// - Single req0: a=32'h3FC0_0000, b=32'h4000_0000; core returns 32'h4040_0000, flags 0 -> rsp_valid=2'b01, rsp_z=32'h4040_0000, rsp_status=0.
// - Both valid from reset: grants req0, then req1, then req0; req_ready never 2'b11; mul_start one pulse per op.
// - Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_z/rsp_status stable, req_ready=0 throughout.
// - Flags pass-through: mul_flags=6'b000010 (inf) -> rsp_status=7'b000_0010.
// - TIMEOUT_EN, TIMEOUT_CYCLES=4, no mul_done -> rsp_z=32'h7FC0_0000, rsp_status=7'b100_0100; done at expiry gives normal result.

Source files
------------

// File: rtl/fp_mult_arbiter.sv
// Round-robin front end sharing one multi-cycle FP32 multiplier core between two requesters.
// Optional watchdog abort of a stuck core: define FP_MULT_ARB_TIMEOUT_EN.
module fp_mult_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TW             = 7
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [63:0] req_a_i,
    input  logic [63:0] req_b_i,
    output logic [1:0]  rsp_valid_o,
    input  logic [1:0]  rsp_ready_i,
    output logic [31:0] rsp_z_o,
    output logic [6:0]  rsp_status_o,
    output logic        mul_start_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic        mul_done_i,
    input  logic [31:0] mul_z_i,
    input  logic [5:0]  mul_flags_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 2 || (2 ** TW) <= TIMEOUT_CYCLES) begin : g_param_check
        $error("fp_mult_arbiter: TIMEOUT_CYCLES must be >= 2 and < 2**TW");
    end

    state_t      state_q, state_d;
    logic        last_grant_q;
    logic        owner_q;
    logic [31:0] mul_a_q, mul_b_q;
    logic [31:0] rsp_z_q;
    logic [6:0]  rsp_status_q;
    logic        winner;
    logic        accept;
    logic        expire;

    // Contention goes to whoever did not win last time; otherwise the lone requester.
    always_comb begin
        if (&req_valid_i) winner = ~last_grant_q;
        else              winner = req_valid_i[1];
        accept = (state_q == S_IDLE) && (|req_valid_i);
    end

`ifdef FP_MULT_ARB_TIMEOUT_EN
    logic [TW-1:0] cnt_q;

    assign expire = (state_q == S_WAIT) && !mul_done_i && (cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                cnt_q <= '0;
        else if (state_q == S_ISSUE) cnt_q <= '0;
        else if (state_q == S_WAIT)  cnt_q <= cnt_q + 1'b1;
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (mul_done_i || expire) state_d = S_RESP;
            S_RESP:  if (rsp_ready_i[owner_q]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = 2'b00;
        rsp_valid_o = 2'b00;
        if (accept) req_ready_o[winner] = 1'b1;
        if (state_q == S_RESP) rsp_valid_o[owner_q] = 1'b1;
        mul_start_o = (state_q == S_ISSUE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_z_q      <= '0;
            rsp_status_q <= '0;
        end else begin
            if (accept) begin
                mul_a_q      <= winner ? req_a_i[63:32] : req_a_i[31:0];
                mul_b_q      <= winner ? req_b_i[63:32] : req_b_i[31:0];
                owner_q      <= winner;
                last_grant_q <= winner;
            end
            // A done arriving on the expiry cycle still delivers the real result.
            if (state_q == S_WAIT && mul_done_i) begin
                rsp_z_q      <= mul_z_i;
                rsp_status_q <= {1'b0, mul_flags_i};
            end else if (expire) begin
                rsp_z_q      <= 32'h7FC0_0000;
                rsp_status_q <= 7'b100_0100;
            end
        end
    end

    assign mul_a_o      = mul_a_q;
    assign mul_b_o      = mul_b_q;
    assign rsp_z_o      = rsp_z_q;
    assign rsp_status_o = rsp_status_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Scoreboard bench for fp_mult_arbiter: a behavioural core plus directed requester traffic.
module tb_fp_mult_arbiter;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [5:0]  fl;
        int          d;
    } core_ent_t;

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] z;
        logic [6:0]  st;
    } exp_ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] req_a, req_b;
    logic [31:0] rsp_z, mul_a, mul_b, mul_z;
    logic [6:0]  rsp_status;
    logic        mul_start, mul_done;
    logic [5:0]  mul_flags;

    core_ent_t core_q[$];
    exp_ent_t  exp_q[$];
    int tests = 0, fails = 0, n_ops = 0, n_start = 0, cyc = 0;
    bit both_seen = 0;

    fp_mult_arbiter #(.TIMEOUT_CYCLES(4), .TW(7)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_z_o(rsp_z), .rsp_status_o(rsp_status),
        .mul_start_o(mul_start), .mul_a_o(mul_a), .mul_b_o(mul_b),
        .mul_done_i(mul_done), .mul_z_i(mul_z), .mul_flags_i(mul_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic plan(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] z, input logic [5:0] fl, input int d,
                        input logic [31:0] ez, input logic [6:0] est, input bit has_rsp);
        core_ent_t c;
        exp_ent_t  e;
        c.a = a; c.b = b; c.z = z; c.fl = fl; c.d = d;
        core_q.push_back(c);
        n_ops++;
        if (has_rsp) begin
            e.vld = (i == 1) ? 2'b10 : 2'b01; e.z = ez; e.st = est;
            exp_q.push_back(e);
        end
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, output int tacc);
        int n = 0;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_valid[i] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 300);
        tacc = cyc;
        if (!req_ready[i]) begin
            tests++; fails++;
            $display("FAIL grant_timeout req%0d: got req_ready=%b, expected bit set", i, req_ready);
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL idle_timeout: got %0d pending responses, expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Response monitor: pops one expectation per completed handshake.
    initial forever begin
        exp_ent_t e;
        @(negedge clk);
        if (req_ready == 2'b11) both_seen = 1;
        if (mul_start) n_start++;
        if (rst_n && (rsp_valid & rsp_ready) != 2'b00) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b z=%h, expected no response", rsp_valid, rsp_z);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_valid", rsp_valid, e.vld);
                chk("rsp_z", rsp_z, e.z);
                chk("rsp_status", rsp_status, e.st);
            end
        end
    end

    // Behavioural core: checks captured operands, answers after d cycles, dies with reset.
    initial begin
        mul_done = 0; mul_z = '0; mul_flags = '0;
        forever begin
            core_ent_t c;
            bit aborted;
            @(negedge clk);
            if (mul_start) begin
                aborted = 0;
                if (core_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL core_unexpected_start: got mul_a=%h, expected no start", mul_a);
                    c.a = mul_a; c.b = mul_b; c.z = '0; c.fl = '0; c.d = 1;
                end else begin
                    c = core_q.pop_front();
                    chk("mul_a", mul_a, c.a);
                    chk("mul_b", mul_b, c.b);
                end
                for (int k = 0; k < c.d && !aborted; k++) begin
                    @(posedge clk);
                    if (!rst_n) aborted = 1;
                end
                if (c.d > 0 && !aborted) begin
                    #1 mul_done = 1; mul_z = c.z; mul_flags = c.fl;
                    @(posedge clk);
                    #1 mul_done = 0; mul_z = '0; mul_flags = '0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int t, n;
        rst_n = 0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", req_ready, 2'b00);
        chk("reset_rsp_valid", rsp_valid, 2'b00);
        chk("reset_mul_start", mul_start, 1'b0);
        chk("reset_mul_ab", {mul_a, mul_b}, 64'h0);
        chk("reset_rsp", {rsp_z, rsp_status}, 64'h0);
        rst_n = 1;
        @(posedge clk); #1;

        // Single req0: 1.5 * 2.0 = 3.0, latency accept->rsp_valid = 3
        plan(0, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 6'd0, 1, 32'h4040_0000, 7'd0, 1);
        issue(0, 32'h3FC0_0000, 32'h4000_0000, t);
        n = 0;
        while (rsp_valid == 2'b00 && n < 50) begin @(negedge clk); n++; end
        chk("latency", cyc - t, 3);
        wait_idle();

        // Flags pass-through on req1 (overflow to inf)
        plan(1, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 6'b000010, 2, 32'h7F80_0000, 7'b000_0010, 1);
        issue(1, 32'h7F00_0000, 32'h4000_0000, t);
        wait_idle();

        // Continuous contention: req1 was last, so req0, req1, req0
        plan(0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 6'd0, 1, 32'h3F80_0000, 7'd0, 1);
        plan(1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 6'b100000, 1, 32'h40C0_0000, 7'b010_0000, 1);
        plan(0, 32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000, 6'd0, 2, 32'hC040_0000, 7'd0, 1);
        fork
            begin
                int t0;
                issue(0, 32'h3F80_0000, 32'h3F80_0000, t0);
                issue(0, 32'hBFC0_0000, 32'h4000_0000, t0);
            end
            begin
                int t1;
                issue(1, 32'h4000_0000, 32'h4040_0000, t1);
            end
        join
        wait_idle();

        // Backpressure: response held, competing req0 not accepted meanwhile
        plan(1, 32'h4080_0000, 32'h3F00_0000, 32'h4000_0000, 6'd0, 1, 32'h4000_0000, 7'd0, 1);
        plan(0, 32'h4120_0000, 32'h4120_0000, 32'h42C8_0000, 6'd0, 1, 32'h42C8_0000, 7'd0, 1);
        rsp_ready = 2'b00;
        issue(1, 32'h4080_0000, 32'h3F00_0000, t);
        req_a[31:0] = 32'h4120_0000; req_b[31:0] = 32'h4120_0000; req_valid[0] = 1'b1;
        n = 0;
        while (rsp_valid == 2'b00 && n < 50) begin @(negedge clk); n++; end
        repeat (5) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 2'b10);
            chk("bp_rsp_z", rsp_z, 32'h4000_0000);
            chk("bp_rsp_status", rsp_status, 7'd0);
            chk("bp_req_ready", req_ready, 2'b00);
        end
        @(posedge clk); #1 rsp_ready = 2'b01;
        repeat (2) begin
            @(negedge clk);
            chk("bp_wrong_ready_ignored", rsp_valid, 2'b10);
        end
        @(posedge clk); #1 rsp_ready = 2'b11;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 50);
        chk("bp_req0_granted_after", req_ready, 2'b01);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_idle();

        // Reset mid-WAIT: op discarded, everything back to reset values at once
        plan(0, 32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 6'd0, 20, 32'h0, 7'd0, 0);
        issue(0, 32'h4040_0000, 32'h4040_0000, t);
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 2'b00);
        chk("midrst_mul_start", mul_start, 1'b0);
        chk("midrst_mul_ab", {mul_a, mul_b}, 64'h0);
        chk("midrst_rsp", {rsp_z, rsp_status}, 64'h0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        // After reset last_grant is 1 again, so contention goes to req0 first
        plan(0, 32'h40A0_0000, 32'h4000_0000, 32'h4120_0000, 6'd0, 1, 32'h4120_0000, 7'd0, 1);
        plan(1, 32'h3F80_0000, 32'h4080_0000, 32'h4080_0000, 6'b000001, 3, 32'h4080_0000, 7'b000_0001, 1);
        fork
            begin int t0; issue(0, 32'h40A0_0000, 32'h4000_0000, t0); end
            begin int t1; issue(1, 32'h3F80_0000, 32'h4080_0000, t1); end
        join
        wait_idle();

`ifdef FP_MULT_ARB_TIMEOUT_EN
        // Watchdog with 4 WAIT cycles: no done, done on expiry cycle, done one cycle late
        plan(0, 32'h3F80_0000, 32'h4000_0000, 32'h1234_5678, 6'd0, -1, 32'h7FC0_0000, 7'b100_0100, 1);
        issue(0, 32'h3F80_0000, 32'h4000_0000, t);
        wait_idle();
        plan(1, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 6'd0, 4, 32'h4040_0000, 7'd0, 1);
        issue(1, 32'h3FC0_0000, 32'h4000_0000, t);
        wait_idle();
        plan(0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 6'd0, 5, 32'h7FC0_0000, 7'b100_0100, 1);
        issue(0, 32'h4000_0000, 32'h4000_0000, t);
        wait_idle();
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("mul_start_pulses", n_start, n_ops);
        chk("req_ready_never_both", both_seen, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("core_queue_drained", core_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
